id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/riscv_pkg.sv | 135 +++++++++++++
 rtl/id_stage_if.sv | 38 +++
 rtl/id_stage_regfile.sv | 48 ++++
 rtl/id_stage.sv | 86 ++++++++
 tb/tb_id_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants and the instruction decoder.
//   alu_op_e : ALU operation encoding emitted by the decode stage
//   OP_*     : major opcodes handled (R, I-ALU, LOAD, STORE, BRANCH)
//   F3_*/F7_*: funct3 / funct7 values recognised
//   dec_t    : decoded control word, no register values
//   id_out_t : registered decode-stage output bundle
//   decode() : pure combinational decode of one 32-bit instruction
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        alu_op_e          alu_op;
        logic             use_imm;   // src2 takes imm instead of x[rs2]
        logic [XLEN-1:0]  imm;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             illegal;
    } dec_t;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        alu_op_e         alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            illegal;
    } id_out_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t            d;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm_i;
        logic [XLEN-1:0] imm_s;
        logic [XLEN-1:0] imm_b;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        d         = '0;
        d.illegal = 1'b1;    // cleared by each recognised encoding
        case (op)
            OP_R: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  begin d.alu_op = ALU_ADD; d.illegal = 1'b0; end
                        F3_AND:  begin d.alu_op = ALU_AND; d.illegal = 1'b0; end
                        F3_OR:   begin d.alu_op = ALU_OR;  d.illegal = 1'b0; end
                        F3_SLT:  begin d.alu_op = ALU_SLT; d.illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (f7 == F7_SUB && f3 == F3_ADD) begin
                    d.alu_op  = ALU_SUB;
                    d.illegal = 1'b0;
                end
                d.reg_write = 1'b1;
            end
            OP_IMM: begin
                case (f3)
                    F3_ADD:  begin d.alu_op = ALU_ADD; d.illegal = 1'b0; end
                    F3_AND:  begin d.alu_op = ALU_AND; d.illegal = 1'b0; end
                    F3_OR:   begin d.alu_op = ALU_OR;  d.illegal = 1'b0; end
                    F3_SLT:  begin d.alu_op = ALU_SLT; d.illegal = 1'b0; end
                    default: ;
                endcase
                d.use_imm   = 1'b1;
                d.imm       = imm_i;
                d.reg_write = 1'b1;
            end
            OP_LOAD: if (f3 == F3_LW) begin
                d.illegal   = 1'b0;
                d.use_imm   = 1'b1;
                d.imm       = imm_i;
                d.mem_read  = 1'b1;
                d.reg_write = 1'b1;
            end
            OP_STORE: if (f3 == F3_SW) begin
                d.illegal   = 1'b0;
                d.use_imm   = 1'b1;
                d.imm       = imm_s;
                d.mem_write = 1'b1;
            end
            OP_BRANCH: if (f3 == F3_BEQ) begin
                d.illegal = 1'b0;
                d.alu_op  = ALU_SUB;   // compare by subtraction
                d.imm     = imm_b;
                d.branch  = 1'b1;
            end
            default: ;
        endcase
        // Anything unrecognised collapses to a clean all-zero control word.
        if (d.illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: bundles the decode stage's fetch handshake, execute handshake
// with decoded payload, register-file write-back port and flush.
//   slave  : decode-stage view (id_stage)
//   master : surrounding pipeline / bench view
interface id_stage_if #(parameter int N = 32);
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] src1;
    logic [N-1:0] src2;
    logic [N-1:0] store_data;
    logic [N-1:0] imm;
    logic [4:0]   rd;
    logic [2:0]   alu_op;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         illegal;
    logic         wb_en;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_data;
    logic         flush;

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_rd, wb_data, flush,
        output in_ready, out_valid, src1, src2, store_data, imm, rd, alu_op,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_rd, wb_data, flush,
        input  in_ready, out_valid, src1, src2, store_data, imm, rd, alu_op,
               reg_write, mem_read, mem_write, branch, illegal
    );
endinterface

// File: rtl/id_stage_regfile.sv
// regfile: 31 x N architectural registers (x0 hard-wired to zero).
//   ra1/ra2 -> rd1/rd2 : combinational read ports with write-through bypass
//   we/wa/wd           : synchronous write port, writes to x0 dropped
//   rst                : synchronous, active-high, clears every register
module regfile #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         we,
    input  logic [4:0]   wa,
    input  logic [N-1:0] wd
);
    localparam int NRD = 2;

    logic [31:1][N-1:0]    regs_q, regs_d;
    logic [NRD-1:0][4:0]   ra;
    logic [NRD-1:0][N-1:0] rdata;

    assign ra  = {ra2, ra1};
    assign rd1 = rdata[0];
    assign rd2 = rdata[1];

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end

    // A same-cycle write to the addressed register is forwarded so the
    // reader sees the value the register will hold after this edge.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ra[p] == 5'd0)            rdata[p] = '0;
            else if (we && wa == ra[p])   rdata[p] = wd;
            else                          rdata[p] = regs_q[ra[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a single output register.
//   clk, rst : clock and synchronous active-high reset
//   io       : id_stage_if.slave -- fetch handshake (in_valid/in_ready/instr),
//              execute handshake and payload (out_valid/out_ready, src1, src2,
//              store_data, imm, rd, alu_op, control bits), write-back port
//              (wb_en/wb_rd/wb_data) and flush.
// Operands are captured at accept; latency is one cycle; full throughput.
// Only N = 32 is meaningful (RV32I).
module id_stage
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   io
);
    logic         out_valid_q, out_valid_d;
    id_out_t      out_q, out_d;
    dec_t         dec;
    logic [N-1:0] rs1_val, rs2_val;
    logic         accept;

    regfile #(.N(N)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (io.instr[19:15]),
        .ra2 (io.instr[24:20]),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (io.wb_en),
        .wa  (io.wb_rd),
        .wd  (io.wb_data)
    );

    assign dec         = decode(io.instr);
    assign io.in_ready = (~out_valid_q | io.out_ready) & ~io.flush;
    assign accept      = io.in_valid & io.in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (io.flush) begin
            // Payload is left as-is; only validity is dropped.
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d      = 1'b1;
            out_d.src1       = rs1_val;
            out_d.src2       = dec.use_imm ? dec.imm : rs2_val;
            out_d.store_data = rs2_val;
            out_d.imm        = dec.imm;
            out_d.rd         = io.instr[11:7];
            out_d.alu_op     = dec.alu_op;
            out_d.reg_write  = dec.reg_write;
            out_d.mem_read   = dec.mem_read;
            out_d.mem_write  = dec.mem_write;
            out_d.branch     = dec.branch;
            out_d.illegal    = dec.illegal;
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.src1       = out_q.src1;
    assign io.src2       = out_q.src2;
    assign io.store_data = out_q.store_data;
    assign io.imm        = out_q.imm;
    assign io.rd         = out_q.rd;
    assign io.alu_op     = out_q.alu_op;
    assign io.reg_write  = out_q.reg_write;
    assign io.mem_read   = out_q.mem_read;
    assign io.mem_write  = out_q.mem_write;
    assign io.branch     = out_q.branch;
    assign io.illegal    = out_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage. A mnemonic-level model tracks
// the architectural registers and the one-deep output slot; a compare process
// checks every output on every falling edge, and directed literal checks pin
// the model on known instructions.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    id_stage_if #(.N(32)) io ();
    id_stage #(.N(32)) dut (.clk(clk), .rst(rst), .io(io));

    typedef struct {
        logic [31:0] src1, src2, sd, imm;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        rw, mr, mw, br, il;
    } exp_t;

    logic [31:0] m_regs [32];
    exp_t        m_out;
    logic        m_valid;
    logic        model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (io.wb_en && io.wb_rd == r) return io.wb_data;
        return m_regs[r];
    endfunction

    // Table decode keyed on {funct7, funct3, opcode}.
    function automatic exp_t model_decode(input logic [31:0] i);
        exp_t        e;
        logic [16:0] key;
        logic [31:0] a, b, ii, is, ib;
        a   = rd_reg(i[19:15]);
        b   = rd_reg(i[24:20]);
        ii  = {{20{i[31]}}, i[31:20]};
        is  = {{20{i[31]}}, i[31:25], i[11:7]};
        ib  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        key = {i[31:25], i[14:12], i[6:0]};
        e = '{src1: a, src2: b, sd: b, imm: 32'd0, rd: i[11:7], op: 3'd0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, il: 1'b0};
        casez (key)
            17'b0000000_000_0110011: begin e.op = 3'b000; e.rw = 1; end
            17'b0100000_000_0110011: begin e.op = 3'b001; e.rw = 1; end
            17'b0000000_111_0110011: begin e.op = 3'b010; e.rw = 1; end
            17'b0000000_110_0110011: begin e.op = 3'b011; e.rw = 1; end
            17'b0000000_010_0110011: begin e.op = 3'b101; e.rw = 1; end
            17'b???????_000_0010011: begin e.op = 3'b000; e.rw = 1; e.imm = ii; e.src2 = ii; end
            17'b???????_111_0010011: begin e.op = 3'b010; e.rw = 1; e.imm = ii; e.src2 = ii; end
            17'b???????_110_0010011: begin e.op = 3'b011; e.rw = 1; e.imm = ii; e.src2 = ii; end
            17'b???????_010_0010011: begin e.op = 3'b101; e.rw = 1; e.imm = ii; e.src2 = ii; end
            17'b???????_010_0000011: begin e.rw = 1; e.mr = 1; e.imm = ii; e.src2 = ii; end
            17'b???????_010_0100011: begin e.mw = 1; e.imm = is; e.src2 = is; end
            17'b???????_000_1100011: begin e.op = 3'b001; e.br = 1; e.imm = ib; end
            default:                 e.il = 1;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        logic ir;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
            m_out = '{src1: 0, src2: 0, sd: 0, imm: 0, rd: 0, op: 0,
                      rw: 0, mr: 0, mw: 0, br: 0, il: 0};
            m_valid  = 1'b0;
            model_ok = 1'b1;
        end else begin
            ir = (!m_valid || io.out_ready) && !io.flush;
            if (io.in_valid && ir) begin
                m_out   = model_decode(io.instr);
                m_valid = 1'b1;
            end else if (io.flush || io.out_ready) begin
                m_valid = 1'b0;
            end
            if (io.wb_en && io.wb_rd != 0) m_regs[io.wb_rd] = io.wb_data;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("out_valid",  32'(io.out_valid), 32'(m_valid));
            check("in_ready",   32'(io.in_ready),
                  32'((!m_valid || io.out_ready) && !io.flush));
            check("src1",       io.src1,        m_out.src1);
            check("src2",       io.src2,        m_out.src2);
            check("store_data", io.store_data,  m_out.sd);
            check("imm",        io.imm,         m_out.imm);
            check("rd",         32'(io.rd),     32'(m_out.rd));
            check("alu_op",     32'(io.alu_op), 32'(m_out.op));
            check("reg_write",  32'(io.reg_write), 32'(m_out.rw));
            check("mem_read",   32'(io.mem_read),  32'(m_out.mr));
            check("mem_write",  32'(io.mem_write), 32'(m_out.mw));
            check("branch",     32'(io.branch),    32'(m_out.br));
            check("illegal",    32'(io.illegal),   32'(m_out.il));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        io.wb_en = 1; io.wb_rd = r; io.wb_data = v;
        cyc();
        io.wb_en = 0;
    endtask

    task automatic issue(input logic [31:0] ins);
        io.in_valid = 1; io.instr = ins;
        cyc();
    endtask

    initial begin
        rst = 1;
        io.in_valid = 0; io.instr = 0; io.out_ready = 0;
        io.wb_en = 0; io.wb_rd = 0; io.wb_data = 0; io.flush = 0;
        cyc(); cyc();
        rst = 0;
        check("lit_reset_valid", 32'(io.out_valid), 32'd0);
        check("lit_reset_src1", io.src1, 32'd0);

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);
        io.out_ready = 1;

        issue(32'h002081B3);                       // add x3,x1,x2
        check("lit_add_valid", 32'(io.out_valid), 32'd1);
        check("lit_add_src1", io.src1, 32'd5);
        check("lit_add_src2", io.src2, 32'd3);
        check("lit_add_op", 32'(io.alu_op), 32'd0);
        check("lit_add_rd", 32'(io.rd), 32'd3);
        check("lit_add_rw", 32'(io.reg_write), 32'd1);

        issue(32'h402081B3);                       // sub x3,x1,x2
        check("lit_sub_op", 32'(io.alu_op), 32'd1);

        issue(32'hFFF0A213);                       // slti x4,x1,-1
        check("lit_slti_op", 32'(io.alu_op), 32'd5);
        check("lit_slti_src2", io.src2, 32'hFFFFFFFF);

        issue(32'h0020A423);                       // sw x2,8(x1)
        check("lit_sw_src2", io.src2, 32'd8);
        check("lit_sw_sd", io.store_data, 32'd3);
        check("lit_sw_mw", 32'(io.mem_write), 32'd1);
        check("lit_sw_rw", 32'(io.reg_write), 32'd0);

        issue(32'hFFFFFFFF);
        check("lit_ill", 32'(io.illegal), 32'd1);
        check("lit_ill_ctl", 32'({io.reg_write, io.mem_read, io.mem_write, io.branch}), 32'd0);

        issue(32'h0040A283);                       // lw x5,4(x1)
        check("lit_lw_mr", 32'(io.mem_read), 32'd1);
        check("lit_lw_src2", io.src2, 32'd4);

        issue(32'h0020F333);                       // and x6,x1,x2
        issue(32'h0020A3B3);                       // slt x7,x1,x2
        issue(32'h00109093);                       // slli: unsupported -> illegal
        check("lit_slli_ill", 32'(io.illegal), 32'd1);

        issue(32'hFE208EE3);                       // beq x1,x2,-4
        check("lit_beq_imm", io.imm, 32'hFFFFFFFC);
        check("lit_beq_br", 32'(io.branch), 32'd1);
        check("lit_beq_src2", io.src2, 32'd3);

        // Stall: held beq must not move, no accept.
        io.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            issue(32'h002081B3);
            check("lit_stall_ready", 32'(io.in_ready), 32'd0);
            check("lit_stall_imm", io.imm, 32'hFFFFFFFC);
        end
        io.out_ready = 1;
        issue(32'h002081B3);
        check("lit_resume_rd", 32'(io.rd), 32'd3);
        issue(32'h402081B3);
        check("lit_b2b_op", 32'(io.alu_op), 32'd1);

        // Write-through bypass on the accept cycle.
        io.wb_en = 1; io.wb_rd = 1; io.wb_data = 32'h1234;
        issue(32'h000081B3);                       // add x3,x1,x0
        io.wb_en = 0;
        check("lit_bypass_src1", io.src1, 32'h1234);

        // x0 write is ignored.
        io.in_valid = 0;
        wb(5'd0, 32'hDEAD);
        issue(32'h000001B3);                       // add x3,x0,x0
        check("lit_x0_src1", io.src1, 32'd0);

        // Flush during stall with incoming instruction.
        io.out_ready = 0;
        io.flush = 1;
        issue(32'h002081B3);
        check("lit_flush_valid", 32'(io.out_valid), 32'd0);
        io.flush = 0; io.in_valid = 0;
        cyc();
        check("lit_flush_drop", 32'(io.out_valid), 32'd0);

        // Reset mid-stall, with a competing write-back.
        io.out_ready = 1;
        issue(32'h002081B3);
        io.out_ready = 0;
        cyc();
        rst = 1; io.wb_en = 1; io.wb_rd = 1; io.wb_data = 32'h77;
        cyc();
        rst = 0; io.wb_en = 0;
        check("lit_rst_valid", 32'(io.out_valid), 32'd0);
        io.out_ready = 1;
        issue(32'h000081B3);
        check("lit_rst_x1", io.src1, 32'd0);
        io.in_valid = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
